// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop recovery, LSB-first, with a
// one-deep holding register, read handshake, framing-error and overrun flags.
module uart_rx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SB_TICK    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_ticks,
   input  logic                  i_rx,
   input  logic                  i_rd,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_rx_done,
   output logic                  o_frame_err,
   output logic                  o_overrun
);

   localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int unsigned NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [SW-1:0] SMid  = SW'(7);
   localparam logic [SW-1:0] SBit  = SW'(15);
   localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] NLast = NW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e                state_q, state_d;
   logic [SW-1:0]         s_q, s_d;
   logic [NW-1:0]         n_q, n_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH:0]   shift_ext;

   logic                  rx_meta_q, rx_s_q, rx_q;
   logic                  good, ferr;

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;
   logic                  done_q, ferr_q;

   // Synchroniser and edge-detect flops reset to the idle (high) line level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_q      <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
         rx_q      <= rx_s_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
      end
   end

   assign shift_ext = {rx_s_q, shift_q};

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      good    = 1'b0;
      ferr    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Only a high-to-low transition starts a frame, so a held-low line is ignored.
            if (rx_q && !rx_s_q) begin
               state_d = StStart;
               s_d     = '0;
            end
         end
         StStart: begin
            if (i_ticks) begin
               if (s_q == SMid) begin
                  s_d = '0;
                  if (!rx_s_q) begin
                     state_d = StData;
                     n_d     = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         StData: begin
            if (i_ticks) begin
               if (s_q == SBit) begin
                  s_d     = '0;
                  shift_d = shift_ext[DATA_WIDTH:1];
                  if (n_q == NLast) begin
                     state_d = StStop;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (i_ticks) begin
               if (s_q == SStop) begin
                  s_d     = '0;
                  state_d = StIdle;
                  good    = rx_s_q;
                  ferr    = !rx_s_q;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A read coincident with a load still clears overrun; the new word wins.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (i_rd && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (good) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         if (valid_q && !i_rd) begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         done_q  <= good;
         ferr_q  <= ferr;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_rx_done   = done_q;
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives framed serial data against a
// free-running tick and compares against a word-level holding-register model.
module tb_uart_rx;

   localparam int DW   = 8;
   localparam int SB   = 16;
   localparam int TDIV = 4;
   localparam int BIT  = 16 * TDIV;
   // Cycle (relative to start-bit edge) in which the stop bit is judged.
   localparam int LOAD_OFS = 8 * TDIV + 16 * TDIV * DW + TDIV * SB - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_ticks;
   logic          i_rx;
   logic          i_rd;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_rx_done;
   logic          o_frame_err;
   logic          o_overrun;

   int cyc = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   int done_cyc = 0;
   int errors = 0;
   int checks = 0;

   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ovr;

   uart_rx #(
      .DATA_WIDTH(DW),
      .SB_TICK   (SB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_ticks    (i_ticks),
      .i_rx       (i_rx),
      .i_rd       (i_rd),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_rx_done  (o_rx_done),
      .o_frame_err(o_frame_err),
      .o_overrun  (o_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_rx_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
   end

   initial begin
      i_ticks = 1'b0;
      forever begin
         @(posedge clk);
         #1 i_ticks = ((cyc % TDIV) == TDIV - 1);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Word-level model of the holding register.
   task automatic model_frame(input logic [DW-1:0] w, input logic stop, input logic rd);
      if (stop) begin
         if (rd && m_valid) m_ovr = 1'b0;
         else if (m_valid) m_ovr = 1'b1;
         m_valid = 1'b1;
         m_data  = w;
      end else if (rd && m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic pulse_rd();
      i_rd = 1'b1;
      wait_cyc(1);
      i_rd = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   // Sends start, DW data bits LSB-first, and a stop bit of level 'stop'.
   // rd_at / rst_at: frame-relative cycle for an i_rd pulse / reset assertion (-1 = none).
   task automatic send_frame(input logic [DW-1:0] w, input logic stop, input int rd_at,
                             input int rst_at, output int c0);
      logic [DW+1:0] fr;
      fr   = {stop, w, 1'b0};
      i_rx = 1'b1;
      wait_cyc(8);
      while ((cyc % TDIV) != 0) wait_cyc(1);
      c0 = cyc;
      for (int c = 0; c < (DW + 2) * BIT; c++) begin
         i_rx = fr[c / BIT];
         i_rd = (c == rd_at);
         if (c == rst_at) begin
            reset = 1'b0;
            break;
         end
         wait_cyc(1);
      end
      i_rd = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      i_rx  = 1'b1;
      i_rd  = 1'b0;
      model_reset();
      wait_cyc(3);
      checks++;
      if ({o_data, o_valid, o_rx_done, o_frame_err, o_overrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h v=%b d=%b fe=%b ov=%b, expected all 0",
                  o_data, o_valid, o_rx_done, o_frame_err, o_overrun);
      end
      reset = 1'b1;
      wait_cyc(BIT);
      checks++;
      if ({o_data, o_valid, o_rx_done, o_frame_err, o_overrun} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got data=%h v=%b ov=%b, expected all 0",
                  o_data, o_valid, o_overrun);
      end
   endtask

   task automatic test_loopback();
      int c0, d0, f0;
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(8'h2F, 1'b1, -1, -1, c0);
      model_frame(8'h2F, 1'b1, 1'b0);
      wait_cyc(4);
      checks++;
      if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
         errors++;
         $display("FAIL loopback_state: got v=%b ov=%b data=%h, expected v=%b ov=%b data=%h",
                  o_valid, o_overrun, o_data, m_valid, m_ovr, m_data);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL loopback_done_count: got %0d, expected 1", done_cnt - d0);
      end
      checks++;
      if (ferr_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL loopback_ferr_count: got %0d, expected 0", ferr_cnt - f0);
      end
      checks++;
      if (done_cyc !== c0 + LOAD_OFS + 1) begin
         errors++;
         $display("FAIL loopback_latency: got cycle %0d, expected %0d", done_cyc,
                  c0 + LOAD_OFS + 1);
      end
   endtask

   task automatic test_glitch();
      int c0, d0;
      pulse_rd();
      d0   = done_cnt;
      i_rx = 1'b1;
      wait_cyc(8);
      while ((cyc % TDIV) != 0) wait_cyc(1);
      i_rx = 1'b0;
      wait_cyc(3 * TDIV);
      i_rx = 1'b1;
      wait_cyc(3 * BIT);
      checks++;
      if (done_cnt !== d0 || o_frame_err !== 1'b0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL glitch_ignored: got done=%0d v=%b, expected done=0 v=0",
                  done_cnt - d0, o_valid);
      end
      send_frame(8'h55, 1'b1, -1, -1, c0);
      model_frame(8'h55, 1'b1, 1'b0);
      wait_cyc(4);
      checks++;
      if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
         errors++;
         $display("FAIL glitch_next_frame: got v=%b ov=%b data=%h, expected v=%b ov=%b data=%h",
                  o_valid, o_overrun, o_data, m_valid, m_ovr, m_data);
      end
      checks++;
      if (done_cnt - d0 !== 1 || done_cyc !== c0 + LOAD_OFS + 1) begin
         errors++;
         $display("FAIL glitch_next_done: got count=%0d cycle=%0d, expected 1 at %0d",
                  done_cnt - d0, done_cyc, c0 + LOAD_OFS + 1);
      end
   endtask

   task automatic test_frame_err();
      int c0, d0, f0;
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(8'hC3, 1'b0, -1, -1, c0);
      model_frame(8'hC3, 1'b0, 1'b0);
      wait_cyc(3 * (DW + 2) * BIT);
      checks++;
      if (ferr_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_pulse: got %0d cycles high, expected 1", ferr_cnt - f0);
      end
      checks++;
      if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
         errors++;
         $display("FAIL ferr_hold: got v=%b ov=%b data=%h, expected v=%b ov=%b data=%h",
                  o_valid, o_overrun, o_data, m_valid, m_ovr, m_data);
      end
      checks++;
      if (done_cnt !== d0) begin
         errors++;
         $display("FAIL ferr_break_no_frame: got %0d done pulses, expected 0", done_cnt - d0);
      end
      i_rx = 1'b1;
      wait_cyc(2 * BIT);
      checks++;
      if (done_cnt !== d0 || ferr_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_release: got done=%0d ferr=%0d, expected done=0 ferr=1",
                  done_cnt - d0, ferr_cnt - f0);
      end
   endtask

   task automatic test_overrun();
      int c0, d0;
      pulse_rd();
      d0 = done_cnt;
      send_frame(8'hA5, 1'b1, -1, -1, c0);
      model_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, -1, -1, c0);
      model_frame(8'h3C, 1'b1, 1'b0);
      wait_cyc(4);
      checks++;
      if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
         errors++;
         $display("FAIL overrun_set: got v=%b ov=%b data=%h, expected v=%b ov=%b data=%h",
                  o_valid, o_overrun, o_data, m_valid, m_ovr, m_data);
      end
      checks++;
      if (done_cnt - d0 !== 2) begin
         errors++;
         $display("FAIL overrun_done_count: got %0d, expected 2", done_cnt - d0);
      end
      pulse_rd();
      checks++;
      if ({o_valid, o_overrun} !== 2'b00 || o_data !== m_data) begin
         errors++;
         $display("FAIL overrun_read_clear: got v=%b ov=%b data=%h, expected v=0 ov=0 data=%h",
                  o_valid, o_overrun, o_data, m_data);
      end
      wait_cyc(3);
      checks++;
      if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
         errors++;
         $display("FAIL overrun_after_read: got v=%b ov=%b, expected v=%b ov=%b",
                  o_valid, o_overrun, m_valid, m_ovr);
      end
   endtask

   task automatic test_rd_coincident();
      int c0;
      send_frame(8'h11, 1'b1, -1, -1, c0);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, -1, -1, c0);
      model_frame(8'h44, 1'b1, 1'b0);
      wait_cyc(2);
      checks++;
      if (o_overrun !== 1'b1) begin
         errors++;
         $display("FAIL coinc_pre_overrun: got %b, expected 1", o_overrun);
      end
      send_frame(8'h22, 1'b1, LOAD_OFS, -1, c0);
      model_frame(8'h22, 1'b1, 1'b1);
      wait_cyc(4);
      checks++;
      if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
         errors++;
         $display("FAIL coinc_load: got v=%b ov=%b data=%h, expected v=%b ov=%b data=%h",
                  o_valid, o_overrun, o_data, m_valid, m_ovr, m_data);
      end
   endtask

   task automatic test_reset_mid();
      int c0, d0;
      send_frame(8'hFF, 1'b1, -1, 5 * BIT + BIT / 2, c0);
      #1;
      model_reset();
      checks++;
      if ({o_data, o_valid, o_rx_done, o_frame_err, o_overrun} !== '0) begin
         errors++;
         $display("FAIL midreset_immediate: got data=%h v=%b ov=%b, expected all 0",
                  o_data, o_valid, o_overrun);
      end
      i_rx = 1'b1;
      wait_cyc(5);
      reset = 1'b1;
      d0 = done_cnt;
      wait_cyc(3 * BIT);
      checks++;
      if (done_cnt !== d0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_discard: got done=%0d v=%b, expected done=0 v=0",
                  done_cnt - d0, o_valid);
      end
      send_frame(8'h81, 1'b1, -1, -1, c0);
      model_frame(8'h81, 1'b1, 1'b0);
      wait_cyc(4);
      checks++;
      if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
         errors++;
         $display("FAIL midreset_next_frame: got v=%b ov=%b data=%h, expected v=%b ov=%b data=%h",
                  o_valid, o_overrun, o_data, m_valid, m_ovr, m_data);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL midreset_done_count: got %0d, expected 1", done_cnt - d0);
      end
   endtask

   task automatic test_random();
      int            c0, d0, f0;
      logic [DW-1:0] w;
      logic          stop, rdc;
      for (int i = 0; i < 12; i++) begin
         w    = DW'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         rdc  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) pulse_rd();
         d0 = done_cnt;
         f0 = ferr_cnt;
         send_frame(w, stop, rdc ? LOAD_OFS : -1, -1, c0);
         model_frame(w, stop, rdc);
         i_rx = 1'b1;
         wait_cyc(4);
         checks++;
         if ({o_valid, o_overrun, o_data} !== {m_valid, m_ovr, m_data}) begin
            errors++;
            $display("FAIL random_state[%0d]: got v=%b ov=%b data=%h, expected v=%b ov=%b data=%h",
                     i, o_valid, o_overrun, o_data, m_valid, m_ovr, m_data);
         end
         checks++;
         if (done_cnt - d0 !== (stop ? 1 : 0)) begin
            errors++;
            $display("FAIL random_done[%0d]: got %0d, expected %0d", i, done_cnt - d0,
                     stop ? 1 : 0);
         end
         checks++;
         if (ferr_cnt - f0 !== (stop ? 0 : 1)) begin
            errors++;
            $display("FAIL random_ferr[%0d]: got %0d, expected %0d", i, ferr_cnt - f0,
                     stop ? 0 : 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_rd_coincident();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
